rvfi_commit_serializer: RTL

- Sits between the core's multi-port RVFI commit interface and the RVFI trace/checker consumer.
- Captures every commit-port record with valid or trap set into an in-order FIFO and replays the records one per handshake on a single output port.
- Each record is tagged with a monotonically increasing sequence number; overflow is counted, never silently lost.
- The core cannot be stalled by this block; drops are detectable through sequence gaps plus counters.

---
 rtl/rvfi_commit_serializer_if.sv | 52 +++++
 rtl/rvfi_commit_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rvfi_commit_serializer_if.sv
// RVFI record type and the serialized output handshake interface.
// Signals: out_valid_o/out_ready_i handshake, out_rvfi_o record, out_seq_o tag.
package rvfi_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic             valid;
        logic [63:0]      order;
        logic [31:0]      insn;
        logic             trap;
        logic             halt;
        logic             intr;
        logic [1:0]       mode;
        logic [4:0]       cause;
        logic [4:0]       rs1_addr;
        logic [4:0]       rs2_addr;
        logic [XLEN-1:0]  rs1_rdata;
        logic [XLEN-1:0]  rs2_rdata;
        logic [4:0]       rd_addr;
        logic [XLEN-1:0]  rd_wdata;
        logic [XLEN-1:0]  pc_rdata;
        logic [XLEN-1:0]  pc_wdata;
        logic [XLEN-1:0]  mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]  mem_rdata;
        logic [XLEN-1:0]  mem_wdata;
    } rvfi_instr_t;
endpackage

interface rvfi_commit_serializer_if #(
    parameter int SEQ_W = 64
);
    logic                    out_valid_o;
    logic                    out_ready_i;
    rvfi_pkg::rvfi_instr_t   out_rvfi_o;
    logic [SEQ_W-1:0]        out_seq_o;

    modport master (
        output out_valid_o,
        output out_rvfi_o,
        output out_seq_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_rvfi_o,
        input  out_seq_o,
        output out_ready_i
    );
endinterface

// File: rtl/rvfi_commit_serializer.sv
// Multi-port RVFI commit capture into an in-order FIFO, replayed one per handshake.
// Ports: clk_i, rst_i (async high), rvfi_i[], flush_i, out (master), level_o, overflow_o, drop_cnt_o.
module rvfi_commit_serializer #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 16,
    parameter int SEQ_W           = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  rvfi_pkg::rvfi_instr_t        rvfi_i [NR_COMMIT_PORTS],
    input  logic                         flush_i,
    rvfi_commit_serializer_if.master     out,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         overflow_o,
    output logic [SEQ_W-1:0]             drop_cnt_o
);
    import rvfi_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = LW + 1;

    rvfi_instr_t      r_mem     [DEPTH];
    logic [SEQ_W-1:0] r_seq_mem [DEPTH];

    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [LW-1:0]    r_level;
    logic [SEQ_W-1:0] r_next_seq;
    logic             r_overflow;
    logic [SEQ_W-1:0] r_drop_cnt;

    logic             w_valid;
    logic             w_pop;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_k;
    logic [CW-1:0]    w_push;
    logic [CW-1:0]    w_drop;
    logic [AW-1:0]    w_rptr_nxt;
    logic [AW-1:0]    w_wptr_nxt;
    logic [SEQ_W:0]   w_drop_sum;
    logic             w_we    [NR_COMMIT_PORTS];
    logic [AW-1:0]    w_waddr [NR_COMMIT_PORTS];
    logic [SEQ_W-1:0] w_wseq  [NR_COMMIT_PORTS];

    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & out.out_ready_i;

    // A pop this cycle frees its slot for this cycle's pushes.
    assign w_free = CW'(DEPTH) - CW'(r_level) + CW'(w_pop);

    // Compact eligible ports in port order; each takes the next slot and tag.
    // Ports past the free space still advance the tag, leaving a visible gap.
    always_comb begin
        w_k = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            w_we[p]    = (rvfi_i[p].valid | rvfi_i[p].trap)
                         && (w_k < w_free) && !flush_i;
            w_waddr[p] = AW'((CW'(r_wptr) + w_k) & CW'(DEPTH - 1));
            w_wseq[p]  = r_next_seq + SEQ_W'(w_k);
            if (rvfi_i[p].valid | rvfi_i[p].trap) begin
                w_k = w_k + CW'(1);
            end
        end
    end

    assign w_push = (w_k > w_free) ? w_free : w_k;
    // Records discarded by a flush are not drops.
    assign w_drop = flush_i ? '0 : (w_k - w_push);

    assign w_rptr_nxt = AW'((CW'(r_rptr) + CW'(w_pop)) & CW'(DEPTH - 1));
    assign w_wptr_nxt = AW'((CW'(r_wptr) + (flush_i ? '0 : w_push))
                            & CW'(DEPTH - 1));
    assign w_drop_sum = {1'b0, r_drop_cnt} + (SEQ_W + 1)'(w_drop);

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (w_we[p]) begin
                r_mem[w_waddr[p]]     <= rvfi_i[p];
                r_seq_mem[w_waddr[p]] <= w_wseq[p];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_level    <= '0;
            r_next_seq <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_next_seq <= r_next_seq + SEQ_W'(w_k);
            if (flush_i) begin
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_level <= '0;
            end else begin
                r_rptr  <= w_rptr_nxt;
                r_wptr  <= w_wptr_nxt;
                r_level <= LW'(CW'(r_level) - CW'(w_pop) + w_push);
            end
            if (w_drop != '0) begin
                r_overflow <= 1'b1;
            end
            r_drop_cnt <= w_drop_sum[SEQ_W] ? '1 : w_drop_sum[SEQ_W-1:0];
        end
    end

    assign out.out_valid_o = w_valid;
    assign out.out_rvfi_o  = w_valid ? r_mem[r_rptr] : '0;
    assign out.out_seq_o   = w_valid ? r_seq_mem[r_rptr] : r_next_seq;

    assign level_o    = r_level;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule
